// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_pkg                                                |
// | Description : Shared types and constants for the PS/2 receive path:  |
// |               receiver state encoding, frame bit positions and       |
// |               default timing parameters.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ps2_pkg;

  // Receiver states: waiting for a start edge, shifting bits, publishing.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DPS  = 2'd1,
    ST_LOAD = 2'd2
  } ps2_state_t;

  // Frame layout, LSB first on the wire.
  localparam int FRAME_BITS = 11;
  localparam int START      = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PAR        = 9;
  localparam int STOP       = 10;

  // Default timing: 2 ms of silence at 50 MHz aborts a frame.
  localparam int DEF_TIMEOUT_CYC = 100000;
  localparam int DEF_TO_W        = 17;
  localparam int DEF_FILTER_LEN  = 8;

  // Odd parity over data+parity: the XOR of all nine bits must be 1.
  function automatic logic odd_parity_bad(input logic [8:0] data_and_par);
    return ~(^data_and_par);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_glitch_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_glitch_filter                                      |
// | Description : Synchronizes the raw PS/2 clock and data lines, debounces|
// |               the clock with a unanimous-vote history window and     |
// |               emits a one-cycle tick on each filtered falling edge.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ps2_glitch_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2d_sync,
  output logic fall_tick
);

  logic                  c_meta;
  logic                  c_sync;
  logic                  d_meta;
  logic                  d_sync;
  logic [FILTER_LEN-1:0] hist;
  logic                  filt;
  logic                  filt_next;

  // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_meta <= ps2c;
      c_sync <= c_meta;
      d_meta <= ps2d;
      d_sync <= d_meta;
    end
  end

  // The filtered clock only moves when the whole history agrees; any mix holds it.
  always_comb begin
    filt_next = filt;
    if (&hist) begin
      filt_next = 1'b1;
    end else if (~|hist) begin
      filt_next = 1'b0;
    end
  end

  // History shift, filtered level and registered falling-edge tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist      <= '1;
      filt      <= 1'b1;
      fall_tick <= 1'b0;
    end else begin
      hist      <= {hist[FILTER_LEN-2:0], c_sync};
      filt      <= filt_next;
      fall_tick <= filt & ~filt_next;
    end
  end

  assign ps2d_sync = d_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_rx_frame                                           |
// | Description : PS/2 device-to-host frame receiver. Shifts in the      |
// |               11-bit frame on filtered falling clock edges, publishes|
// |               the byte with a done tick plus parity/framing flags,   |
// |               and aborts frames that stall beyond TIMEOUT_CYC.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TO_W        = DEF_TO_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_tick,
  output logic       busy
);

  // Counter value at which the stall is declared; the registered tick then
  // lands exactly TIMEOUT_CYC cycles after the last accepted edge.
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC - 1);

  logic                  ps2d_sync;
  logic                  fall_tick;

  ps2_state_t            state;
  ps2_state_t            state_next;
  logic [FRAME_BITS-1:0] b;
  logic [FRAME_BITS-1:0] b_next;
  logic [3:0]            n;
  logic [3:0]            n_next;
  logic [TO_W-1:0]       to_cnt;
  logic [TO_W-1:0]       to_next;
  logic [TO_W-1:0]       to_inc;
  logic [7:0]            dout_next;
  logic                  parity_err_next;
  logic                  frame_err_next;
  logic                  done_next;
  logic                  timeout_next;

  ps2_glitch_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .ps2d_sync (ps2d_sync),
    .fall_tick (fall_tick)
  );

  assign to_inc = to_cnt + 1'b1;

  // Next-state, shift and result logic; every target defaults to holding.
  always_comb begin
    state_next      = state;
    b_next          = b;
    n_next          = n;
    to_next         = to_cnt;
    dout_next       = dout;
    parity_err_next = parity_err;
    frame_err_next  = frame_err;
    done_next       = 1'b0;
    timeout_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall_tick && rx_en) begin
          b_next     = {ps2d_sync, b[FRAME_BITS-1:1]};
          n_next     = 4'd9;
          to_next    = '0;
          state_next = ST_DPS;
        end
      end
      ST_DPS: begin
        // An edge in the same cycle the stall expires still wins.
        if (fall_tick) begin
          b_next  = {ps2d_sync, b[FRAME_BITS-1:1]};
          to_next = '0;
          if (n == 4'd0) begin
            state_next = ST_LOAD;
          end else begin
            n_next = n - 4'd1;
          end
        end else if (to_inc == TO_LIMIT) begin
          to_next      = '0;
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          to_next = to_inc;
        end
      end
      ST_LOAD: begin
        dout_next       = b[DATA_MSB:DATA_LSB];
        parity_err_next = odd_parity_bad(b[PAR:DATA_LSB]);
        frame_err_next  = b[START] | ~b[STOP];
        done_next       = 1'b1;
        state_next      = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      b            <= '0;
      n            <= 4'd0;
      to_cnt       <= '0;
      dout         <= 8'h00;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
      timeout_tick <= 1'b0;
    end else begin
      state        <= state_next;
      b            <= b_next;
      n            <= n_next;
      to_cnt       <= to_next;
      dout         <= dout_next;
      parity_err   <= parity_err_next;
      frame_err    <= frame_err_next;
      rx_done_tick <= done_next;
      timeout_tick <= timeout_next;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ps2_rx_frame                                        |
// | Description : Directed bench for ps2_rx_frame with a result          |
// |               scoreboard filled by the stimulus and drained by a     |
// |               monitor on each rx_done_tick.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ps2_rx_frame;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int TO_W        = 17;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2d = 1'b1;
  logic       ps2c = 1'b1;
  logic       rx_en = 1'b1;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_tick;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_fall = -100000;
  int   done_cnt = 0;
  int   to_cnt = 0;
  int   busy_seen = 0;

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .rx_en        (rx_en),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .timeout_tick (timeout_tick),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sample away from the active edge, drain the scoreboard.
  always @(negedge clk) begin
    if (dut.u_filter.fall_tick === 1'b1) last_fall = cyc;
    if (busy === 1'b1) busy_seen = 1;
    if (rx_done_tick === 1'b1) begin
      exp_t e;
      done_cnt++;
      chk("done_latency", cyc - last_fall, 2);
      chk("sb_pending", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dout", {24'd0, dout}, {24'd0, e.d});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
      end
    end
    if (timeout_tick === 1'b1) begin
      to_cnt++;
      chk("timeout_latency", cyc - last_fall, TIMEOUT_CYC);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par_ok, input logic stop);
    logic p;
    p = par_ok ? ~(^d) : (^d);
    return {stop, p, d, 1'b0};
  endfunction

  // One PS/2 bit every 400 clk; optional 3-cycle low glitch in the high phase.
  task automatic send_bits(input logic [10:0] f, input int nb, input logic glitch);
    for (int i = 0; i < nb; i++) begin
      ps2d = f[i];
      wait_clk(40);
      if (glitch) begin
        ps2c = 1'b0;
        wait_clk(3);
        ps2c = 1'b1;
        wait_clk(57);
      end else begin
        wait_clk(60);
      end
      ps2c = 1'b0;
      wait_clk(200);
      ps2c = 1'b1;
      wait_clk(100);
    end
    ps2d = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop,
                            input logic glitch);
    exp_t e;
    e.d  = d;
    e.pe = ~par_ok;
    e.fe = ~stop;
    exp_q.push_back(e);
    send_bits(mk(d, par_ok, stop), 11, glitch);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, {24'd0, dout}, 32'h0);
    chk({tag, "_flags"}, {28'd0, rx_done_tick, parity_err, frame_err, timeout_tick}, 32'h0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'h0);
  endtask

  initial begin
    // Reset state.
    wait_clk(3);
    chk_reset_outputs("reset");
    reset = 1'b1;
    wait_clk(20);

    // Good 0x1C frame.
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    chk("done_cnt_1c", done_cnt, 1);

    // 0xF0 with wrong parity.
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    chk("done_cnt_f0", done_cnt, 2);

    // 0x55 with bad stop bit, then good 0xAA clears frame_err.
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    chk("frame_err_hold", {31'd0, frame_err}, 1);
    send_frame(8'hAA, 1'b1, 1'b1, 1'b0);
    chk("done_cnt_aa", done_cnt, 4);

    // Glitch while idle must not start a frame.
    ps2c = 1'b0;
    wait_clk(3);
    ps2c = 1'b1;
    wait_clk(50);
    chk("idle_glitch_busy", {31'd0, busy}, 0);

    // Glitched 0x1C frame.
    send_frame(8'h1C, 1'b1, 1'b1, 1'b1);
    chk("done_cnt_glitch", done_cnt, 5);

    // Stall after 5 edges -> timeout.
    send_bits(mk(8'h3C, 1'b1, 1'b1), 5, 1'b0);
    chk("stall_busy", {31'd0, busy}, 1);
    wait_clk(TIMEOUT_CYC + 100);
    chk("timeout_cnt", to_cnt, 1);
    chk("timeout_busy", {31'd0, busy}, 0);
    chk("timeout_no_done", done_cnt, 5);
    chk("timeout_dout", {24'd0, dout}, 32'h1C);

    // rx_en=0: a full frame is ignored.
    rx_en = 1'b0;
    busy_seen = 0;
    send_bits(mk(8'h77, 1'b1, 1'b1), 11, 1'b0);
    wait_clk(50);
    chk("rxen_busy_seen", busy_seen, 0);
    chk("rxen_no_done", done_cnt, 5);
    rx_en = 1'b1;
    wait_clk(20);

    // Reset mid-frame after 6 bits.
    send_bits(mk(8'h29, 1'b1, 1'b1), 6, 1'b0);
    chk("mid_busy", {31'd0, busy}, 1);
    reset = 1'b0;
    wait_clk(2);
    chk_reset_outputs("midreset");
    reset = 1'b1;
    wait_clk(20);
    chk("midreset_no_done", done_cnt, 5);

    // Fresh 0x29 frame after release.
    send_frame(8'h29, 1'b1, 1'b1, 1'b0);
    wait_clk(20);
    chk("done_cnt_final", done_cnt, 6);
    chk("sb_empty", exp_q.size(), 0);
    chk("final_timeouts", to_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
Receive-only PS/2 device-to-host frame deserializer. Samples the raw PS/2 clock and data lines, filters glitches on the clock, detects falling edges and shifts in the 11-bit frame. Outputs each received byte with a one-cycle done tick and per-frame error flags. Sits directly upstream of the monitor/packet logic, which consumes `rx_done_tick` and `dout`.

Parameters:
- FILTER_LEN, 8: number of consecutive synchronized ps2c samples that must agree before the filtered clock changes level.
- TIMEOUT_CYC, 100000: idle clk cycles allowed between falling edges inside a frame before the frame is aborted (2 ms at 50 MHz).
- TO_W, 17: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ps2d  in  1  raw PS/2 data line (asynchronous).
- ps2c  in  1  raw PS/2 clock line (asynchronous).
- rx_en  in  1  enables frame start; does not abort a frame in progress.
- rx_done_tick  out  1  one-cycle pulse; `dout` and the error flags are valid in this cycle.
- dout  out  8  received data byte; holds until the next completed frame.
- parity_err  out  1  odd-parity check failed for the last frame.
- frame_err  out  1  start bit not 0 or stop bit not 1 for the last frame.
- timeout_tick  out  1  one-cycle pulse when an in-progress frame is aborted.
- busy  out  1  high whenever state is not idle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = idle; shift register = 0; bit counter = 0; timeout counter = 0.
  - Synchronizers and filter history reset to all 1s; filtered clock = 1.
  - dout = 0x00; rx_done_tick, parity_err, frame_err, timeout_tick, busy all 0.
  - Reset asserted mid-frame discards the partial frame with no tick.
- Input conditioning:
  - ps2c and ps2d each pass through a 2-FF synchronizer.
  - Synced ps2c shifts into a FILTER_LEN history. The filtered clock becomes 1 when all bits are 1 and 0 when all bits are 0; otherwise it holds.
  - fall_tick is a registered one-cycle pulse on a filtered 1->0 transition.
  - Data is sampled from synced ps2d in the cycle fall_tick is high.
- Frame format, LSB first: b[0] start, b[8:1] data, b[9] parity, b[10] stop.
- State machine (idle, dps, load):
  - idle: on fall_tick with rx_en=1, shift ps2d into b[10], load n=9, clear timeout counter, go to dps. A fall_tick with rx_en=0 is ignored.
  - dps: on fall_tick, shift ps2d in and clear the timeout counter. If n=0, go to load; else decrement n. Without fall_tick, the timeout counter increments. When it reaches TIMEOUT_CYC-1, pulse timeout_tick, go to idle, and leave dout and the error flags unchanged.
  - load: one cycle. On exit to idle, register:
    - dout = b[8:1]
    - parity_err = ~(^b[9:1])
    - frame_err = b[0] | ~b[10]
    - rx_done_tick = 1 for one cycle.
- Latency: rx_done_tick is high exactly 2 clk cycles after the fall_tick that captures the stop bit.
- The tick fires even when errors are flagged; the consumer qualifies with the flags. Flags hold until the next rx_done_tick.
- Simultaneous events:
  - A fall_tick on the same cycle the timeout expires takes priority: the bit is accepted and no timeout fires.
  - A fall_tick in the load state is ignored.
- rx_en deasserted mid-frame: the frame completes normally.
- busy = (state != idle).

Decomposition:
- Shared package ps2_pkg: state encoding (idle, dps, load), frame bit index constants (START=0, PAR=9, STOP=10), default TIMEOUT_CYC.
- One sub-module, ps2_glitch_filter: both synchronizers, the ps2c filter and fall_tick generation. Outputs are sync ps2d and fall_tick.

Test Plan:
All scenarios use FILTER_LEN=8, TIMEOUT_CYC=2000 and a PS/2 bit period of 400 clk.
- Frame 0x1C with correct parity (1) and stop=1 -> one rx_done_tick, dout=0x1C, parity_err=0, frame_err=0, tick 2 cycles after the stop-bit fall_tick.
- Frame 0xF0 sent with parity bit 0 (wrong) -> rx_done_tick, dout=0xF0, parity_err=1, frame_err=0.
- Frame 0x55 sent with stop bit 0 -> rx_done_tick, dout=0x55, frame_err=1; a following good 0xAA clears frame_err.
- 3-cycle low glitch on ps2c while idle and inside a frame -> no extra bit accepted; a 0x1C frame with glitches still yields dout=0x1C.
- Line stops after 5 falling edges -> timeout_tick exactly TIMEOUT_CYC cycles after the last fall_tick, busy=0, no rx_done_tick, dout unchanged. Also with rx_en=0, a full frame is ignored (busy stays 0).
- Assert reset after 6 bits of a frame -> all outputs at reset values. A fresh 0x29 frame after release is received correctly.
